javk_busmem: RTL and testbench

JAVK_BUSMEM -- requirements
Module: javk_busmem

---
 rtl/javk_pkg.sv | 29 ++
 rtl/javk_busmem_array.sv | 27 ++
 rtl/javk_busmem.sv | 132 +++++++++++++
 tb/tb_javk_busmem.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/javk_pkg.sv
// Shared definitions for the javk bus-attached memory: FSM states, rw polarity,
// parameter defaults and the contents of the write-protected region.
package javk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_ADDR_W      = 16;
  localparam int unsigned DEF_DEPTH_LOG2  = 10;
  localparam int unsigned DEF_BASE        = 0;
  localparam int unsigned DEF_ROM_WORDS   = 256;
  localparam int unsigned DEF_WAIT_STATES = 1;

  localparam int unsigned WAIT_CNT_W = 4;

  // Fixed image of the protected region; it can never be written, so it is
  // generated from the word index instead of being held in the array.
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    return idx ^ 32'hC3C3_C3C3;
  endfunction

endpackage

// File: rtl/javk_busmem_array.sv
// Word storage for javk_busmem: synchronous write, combinational read.
module javk_busmem_array
  import javk_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/javk_busmem.sv
// Bus-attached memory slave: address decode, wait-state FSM and write
// protection of the low ROM_WORDS words; storage lives in javk_busmem_array.
module javk_busmem
  import javk_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int unsigned BASE        = DEF_BASE,
  parameter int unsigned ROM_WORDS   = DEF_ROM_WORDS,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addrbus,
  input  logic              rw,
  input  logic              req,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              ready,
  output logic              wp_err
);

  localparam logic [ADDR_W-1:0]     BASE_A    = ADDR_W'(BASE);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    rw_q;
  logic [DATA_W-1:0]       data_q;
  logic                    rom_q;

  logic                    hit;
  logic                    latch;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    idx_rom;
  logic                    arr_we;
  logic [DATA_W-1:0]       arr_rdata;
  logic [DATA_W-1:0]       rd_word;

  // BASE is aligned to the window size, so the decode is an upper-bit match and
  // the word index is simply the low address bits.
  assign hit     = (addrbus[ADDR_W-1:DEPTH_LOG2] == BASE_A[ADDR_W-1:DEPTH_LOG2]);
  assign idx     = addrbus[DEPTH_LOG2-1:0];
  assign idx_rom = (32'(idx) < ROM_WORDS);

  assign rd_word = rom_q ? DATA_W'(rom_word(32'(idx_q))) : arr_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      rw_q   <= RW_WRITE;
      data_q <= '0;
      rom_q  <= 1'b0;
    end else if (latch) begin
      idx_q  <= idx;
      rw_q   <= rw;
      data_q <= data_in;
      rom_q  <= idx_rom;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req && hit) begin
          latch   = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    data_oe  = 1'b0;
    data_out = '0;
    wp_err   = 1'b0;
    arr_we   = 1'b0;
    if (state_q == ST_ACCESS) begin
      ready = 1'b1;
      if (rw_q == RW_READ) begin
        data_oe  = 1'b1;
        data_out = rd_word;
      end else if (rom_q) begin
        wp_err = 1'b1;
      end else begin
        arr_we = 1'b1;
      end
    end
  end

  javk_busmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .addr_i  (idx_q),
    .wdata_i (data_q),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_javk_busmem.sv
// Directed bench for javk_busmem: default instance plus WAIT_STATES=0 and 15
// instances sharing one stimulus bus.
module tb_javk_busmem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        rw  = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  din  = '0;

  logic [7:0] m_data_out, z_data_out, f_data_out;
  logic       m_data_oe,  z_data_oe,  f_data_oe;
  logic       m_ready,    z_ready,    f_ready;
  logic       m_wp_err,   z_wp_err,   f_wp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  javk_busmem dut (
    .clk(clk), .rst(rst), .addrbus(addr), .rw(rw), .req(req), .data_in(din),
    .data_out(m_data_out), .data_oe(m_data_oe), .ready(m_ready), .wp_err(m_wp_err)
  );

  javk_busmem #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .addrbus(addr), .rw(rw), .req(req), .data_in(din),
    .data_out(z_data_out), .data_oe(z_data_oe), .ready(z_ready), .wp_err(z_wp_err)
  );

  javk_busmem #(.WAIT_STATES(15)) dut15 (
    .clk(clk), .rst(rst), .addrbus(addr), .rw(rw), .req(req), .data_in(din),
    .data_out(f_data_out), .data_oe(f_data_oe), .ready(f_ready), .wp_err(f_wp_err)
  );

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic        hit;
    logic        wp;
    logic [7:0]  rdata;
  } row_t;

  row_t tbl[18];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One request pulse on the main instance, observed for 8 cycles.
  task automatic run_row(input int i, input row_t r);
    int first_k = 0, rdy_n = 0, oe_n = 0, wp_n = 0, z_bad = 0;
    logic [7:0] rd = '0;
    @(negedge clk);
    addr = r.addr; rw = r.rw; din = r.wdata; req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m_ready) begin
        rdy_n++;
        if (first_k == 0) begin
          first_k = k;
          rd = m_data_out;
        end
      end
      if (m_data_oe) oe_n++;
      if (m_wp_err)  wp_n++;
      if (!m_data_oe && m_data_out != 8'h00) z_bad++;
      req = 1'b0;
      din = 8'hEE;
      addr = 16'h0155;
    end
    check($sformatf("row%0d latency", i), first_k, r.hit ? 2 : 0);
    check($sformatf("row%0d ready_cycles", i), rdy_n, r.hit ? 1 : 0);
    check($sformatf("row%0d oe_cycles", i), oe_n, (r.hit && r.rw) ? 1 : 0);
    check($sformatf("row%0d wp_cycles", i), wp_n, r.wp ? 1 : 0);
    check($sformatf("row%0d data_out_idle_zero", i), z_bad, 0);
    if (r.hit && r.rw) check($sformatf("row%0d rdata", i), rd, r.rdata);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fm, f0, f15, pulses, last, sp_bad, first_k;
    logic [7:0] dm, d0, d15, rd;

    tbl[0]  = '{16'h0120, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{16'h0120, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5};
    tbl[2]  = '{16'h0010, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00};
    tbl[3]  = '{16'h0010, 1'b1, 8'h00, 1'b1, 1'b0, 8'hD3};
    tbl[4]  = '{16'h0155, 1'b0, 8'h81, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{16'h0155, 1'b1, 8'h00, 1'b1, 1'b0, 8'h81};
    tbl[6]  = '{16'h00FF, 1'b0, 8'h11, 1'b1, 1'b1, 8'h00};
    tbl[7]  = '{16'h00FF, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C};
    tbl[8]  = '{16'h0100, 1'b0, 8'h22, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{16'h0100, 1'b1, 8'h00, 1'b1, 1'b0, 8'h22};
    tbl[10] = '{16'h03FF, 1'b0, 8'h99, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{16'h03FF, 1'b1, 8'h00, 1'b1, 1'b0, 8'h99};
    tbl[12] = '{16'h0000, 1'b1, 8'h00, 1'b1, 1'b0, 8'hC3};
    tbl[13] = '{16'h0300, 1'b0, 8'h42, 1'b1, 1'b0, 8'h00};
    tbl[14] = '{16'h0300, 1'b1, 8'h00, 1'b1, 1'b0, 8'h42};
    tbl[15] = '{16'hFFFF, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[16] = '{16'h0400, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00};
    tbl[17] = '{16'h0120, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5};

    // reset state
    @(negedge clk);
    check("reset ready", m_ready, 0);
    check("reset data_oe", m_data_oe, 0);
    check("reset wp_err", m_wp_err, 0);
    check("reset data_out", m_data_out, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_row(i, tbl[i]);

    // miss held for 10 cycles
    @(negedge clk);
    addr = 16'h0400; rw = 1'b1; req = 1'b1;
    first_k = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_ready || m_data_oe || m_wp_err) first_k++;
    end
    check("miss held outputs", first_k, 0);
    idle(20);

    // WAIT_STATES 0 / 1 / 15 latency with inputs toggling during the wait
    @(negedge clk);
    addr = 16'h0200; rw = 1'b0; din = 8'h6B; req = 1'b1;
    @(negedge clk);
    idle(20);
    addr = 16'h0200; rw = 1'b1; din = 8'h00; req = 1'b1;
    fm = 0; f0 = 0; f15 = 0; dm = '0; d0 = '0; d15 = '0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (m_ready && fm == 0)  begin fm = k;  dm = m_data_out;  end
      if (z_ready && f0 == 0)  begin f0 = k;  d0 = z_data_out;  end
      if (f_ready && f15 == 0) begin f15 = k; d15 = f_data_out; end
      req  = k[0];
      addr = k[0] ? 16'h0201 : 16'h0400;
      din  = 8'(k);
    end
    check("ws0 latency", f0, 1);
    check("ws0 rdata", d0, 8'h6B);
    check("ws1 latency", fm, 2);
    check("ws1 rdata", dm, 8'h6B);
    check("ws15 latency", f15, 16);
    check("ws15 rdata", d15, 8'h6B);
    idle(20);

    // reset during WAIT of a write aborts it
    addr = 16'h0300; rw = 1'b0; din = 8'h77; req = 1'b1;
    @(posedge clk);
    #2;
    check("rst_wait ws0 ready before rst", z_ready, 1);
    rst = 1'b1;
    #1;
    check("rst_wait ready", m_ready, 0);
    check("rst_wait data_oe", m_data_oe, 0);
    check("rst_wait wp_err", m_wp_err, 0);
    check("rst_wait ws0 ready async", z_ready, 0);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    run_row(100, tbl[14]);

    // reset during ACCESS of a read drops outputs immediately
    @(negedge clk);
    addr = 16'h0120; rw = 1'b1; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #2;
    check("rst_acc ready before rst", m_ready, 1);
    check("rst_acc rdata before rst", m_data_out, 8'hA5);
    rst = 1'b1;
    #1;
    check("rst_acc ready", m_ready, 0);
    check("rst_acc data_oe", m_data_oe, 0);
    check("rst_acc data_out", m_data_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(20);

    // back-to-back write/read with req held high
    addr = 16'h0155; rw = 1'b0; din = 8'h5A; req = 1'b1;
    pulses = 0; last = 0; sp_bad = 0; first_k = 0; rd = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (m_ready) begin
        pulses++;
        if (pulses == 1) first_k = k;
        else if (k - last != 3) sp_bad++;
        last = k;
        if (pulses % 2 == 0) rd = m_data_out;
        rw = (pulses % 2 == 1) ? 1'b1 : 1'b0;
        din = 8'h5A;
      end
      if (pulses >= 4) break;
    end
    req = 1'b0;
    check("b2b pulses", pulses, 4);
    check("b2b first latency", first_k, 2);
    check("b2b spacing", sp_bad, 0);
    check("b2b rdata", rd, 8'h5A);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
